// File: rtl/sr_debounce_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : sr_debounce_driver_if
// Description : Button-input / latch-drive bundle for sr_debounce_driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface sr_debounce_driver_if;
    logic set_raw;
    logic reset_raw;
    logic s_out;
    logic r_out;
    logic busy;
    logic dropped;

    // master: the button side / environment; slave: the debounce driver
    modport master (
        output set_raw,
        output reset_raw,
        input  s_out,
        input  r_out,
        input  busy,
        input  dropped
    );

    modport slave (
        input  set_raw,
        input  reset_raw,
        output s_out,
        output r_out,
        output busy,
        output dropped
    );
endinterface
`default_nettype wire

// File: rtl/sr_debounce_driver.sv
`default_nettype none
// ============================================================================
// Module      : sr_debounce_driver
// Description : Synchronises, debounces and edge-detects two push-buttons and
//               issues mutually exclusive stretched pulses to an SR latch.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_debounce_driver #(
    parameter int DB_CYCLES = 4,
    parameter int PULSE_LEN = 2,
    parameter int CNT_W     = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    sr_debounce_driver_if.slave bus
);

    localparam logic [CNT_W-1:0] c_db_last    = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PULSE_S = 2'd1,
        S_PULSE_R = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    // Channel index 0 = set, 1 = reset
    logic [1:0] w_raw;
    logic [1:0] w_evt;
    logic [1:0] w_req;

    assign w_raw = {bus.reset_raw, bus.set_raw};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        logic             r_sync1;
        logic             r_sync2;
        logic             r_db;
        logic             r_db_d;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_db    <= 1'b0;
                r_db_d  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[i];
                r_sync2 <= r_sync1;
                r_db_d  <= r_db;
                if (r_sync2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_last) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_evt[i] = r_db & ~r_db_d;
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] w_pcnt_next;
    logic [1:0]       r_pend;
    logic [1:0]       w_pend_next;
    logic             w_drop;
    logic             r_s_out;
    logic             r_r_out;
    logic             r_busy;
    logic             r_dropped;

    assign w_req = w_evt | r_pend;

    always_comb begin
        w_next_state = r_state;
        w_pcnt_next  = r_pcnt;
        w_pend_next  = r_pend | w_evt;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Every request visible in IDLE is either serviced or dropped here
                w_pend_next = '0;
                if (w_req[1]) begin
                    w_next_state = S_PULSE_R;
                    w_pcnt_next  = c_pulse_last;
                    w_drop       = w_req[0];
                end else if (w_req[0]) begin
                    w_next_state = S_PULSE_S;
                    w_pcnt_next  = c_pulse_last;
                end
            end
            S_PULSE_S, S_PULSE_R: begin
                if (r_pcnt == '0) begin
                    w_next_state = S_GAP;
                end else begin
                    w_pcnt_next = r_pcnt - 1'b1;
                end
            end
            S_GAP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pcnt    <= '0;
            r_pend    <= '0;
            r_s_out   <= 1'b0;
            r_r_out   <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pcnt    <= w_pcnt_next;
            r_pend    <= w_pend_next;
            // Outputs are registered decodes of the state being entered
            r_s_out   <= (w_next_state == S_PULSE_S);
            r_r_out   <= (w_next_state == S_PULSE_R);
            r_busy    <= (w_next_state != S_IDLE);
            r_dropped <= w_drop;
        end
    end

    assign bus.s_out   = r_s_out;
    assign bus.r_out   = r_r_out;
    assign bus.busy    = r_busy;
    assign bus.dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_sr_debounce_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_debounce_driver
// Description : Directed self-checking bench for sr_debounce_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_debounce_driver;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sr_debounce_driver_if bus_if ();

    sr_debounce_driver #(
        .DB_CYCLES (4),
        .PULSE_LEN (2),
        .CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic es, input logic er,
                        input logic eb, input logic ed);
        tick();
        chk({tag, ".s_out"},   bus_if.s_out,   es);
        chk({tag, ".r_out"},   bus_if.r_out,   er);
        chk({tag, ".busy"},    bus_if.busy,    eb);
        chk({tag, ".dropped"}, bus_if.dropped, ed);
    endtask

    task automatic expect_idle(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Edges 7..10 after the first raw=1 sample
    task automatic expect_pulse(input string tag, input logic is_r, input logic drop);
        step({tag, ".e7"},  ~is_r, is_r, 1'b1, drop);
        step({tag, ".e8"},  ~is_r, is_r, 1'b1, 1'b0);
        step({tag, ".e9"},  1'b0,  1'b0, 1'b1, 1'b0);
        step({tag, ".e10"}, 1'b0,  1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        chk("excl", bus_if.s_out & bus_if.r_out, 1'b0);
    end

    initial begin
        logic [8:0] bounce;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus_if.set_raw   = 1'b0;
        bus_if.reset_raw = 1'b0;

        // Reset with toggling buttons
        for (int i = 0; i < 3; i++) begin
            bus_if.set_raw   = i[0];
            bus_if.reset_raw = ~i[0];
            step("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        bus_if.set_raw   = 1'b0;
        bus_if.reset_raw = 1'b0;
        expect_idle("post_rst", 6);

        // Clean set press
        bus_if.set_raw = 1'b1;
        expect_idle("set_wait", 6);
        expect_pulse("set", 1'b0, 1'b0);
        bus_if.set_raw = 1'b0;
        expect_idle("set_rel", 10);

        // Bounce: highs of 1, 2, 3 cycles separated by single lows
        bounce = 9'b0_111_0_11_0_1;
        for (int i = 0; i < 9; i++) begin
            bus_if.set_raw = bounce[i];
            step("bounce", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        bus_if.set_raw = 1'b1;
        expect_idle("bnc_wait", 6);
        expect_pulse("bnc", 1'b0, 1'b0);
        bus_if.set_raw = 1'b0;
        expect_idle("bnc_rel", 10);

        // Simultaneous press: reset wins, set dropped
        bus_if.set_raw   = 1'b1;
        bus_if.reset_raw = 1'b1;
        expect_idle("sim_wait", 6);
        expect_pulse("sim", 1'b1, 1'b1);
        expect_idle("sim_after", 4);
        bus_if.set_raw   = 1'b0;
        bus_if.reset_raw = 1'b0;
        expect_idle("sim_rel", 10);

        // Reset event arrives during PULSE_S
        bus_if.set_raw = 1'b1;
        step("b2b.e1", 1'b0, 1'b0, 1'b0, 1'b0);
        bus_if.reset_raw = 1'b1;
        expect_idle("b2b_wait", 5);
        step("b2b.e7",  1'b1, 1'b0, 1'b1, 1'b0);
        step("b2b.e8",  1'b1, 1'b0, 1'b1, 1'b0);
        step("b2b.e9",  1'b0, 1'b0, 1'b1, 1'b0);
        step("b2b.e10", 1'b0, 1'b0, 1'b0, 1'b0);
        step("b2b.e11", 1'b0, 1'b1, 1'b1, 1'b0);
        step("b2b.e12", 1'b0, 1'b1, 1'b1, 1'b0);
        step("b2b.e13", 1'b0, 1'b0, 1'b1, 1'b0);
        step("b2b.e14", 1'b0, 1'b0, 1'b0, 1'b0);
        bus_if.set_raw   = 1'b0;
        bus_if.reset_raw = 1'b0;
        expect_idle("b2b_rel", 10);

        // Reset mid PULSE_R with a pending set
        bus_if.reset_raw = 1'b1;
        step("mid.e1", 1'b0, 1'b0, 1'b0, 1'b0);
        bus_if.set_raw = 1'b1;
        expect_idle("mid_wait", 5);
        step("mid.e7", 1'b0, 1'b1, 1'b1, 1'b0);
        step("mid.e8", 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        bus_if.set_raw   = 1'b0;
        bus_if.reset_raw = 1'b0;
        step("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        expect_idle("mid_quiet", 12);
        bus_if.set_raw = 1'b1;
        expect_idle("mid_new_wait", 6);
        expect_pulse("mid_new", 1'b0, 1'b0);
        bus_if.set_raw = 1'b0;
        expect_idle("mid_rel", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_debounce_driver.md
Name: sr_debounce_driver

Overview:
- Front-end stage that drives the r/s inputs of the team's SR latch from two raw, bouncy, asynchronous push-button inputs.
- Each input is synchronised, debounced and rising-edge detected.
- The resulting events are emitted as clean, registered, stretched pulses on s_out/r_out.
- s_out and r_out are never high in the same cycle, and at least one idle cycle separates consecutive pulses, so the latch never sees the forbidden r=s=1 condition.

Parameters:
DB_CYCLES, 4, consecutive synchronised cycles a new level must hold before it is accepted (>=2)
PULSE_LEN, 2, cycles each s_out/r_out pulse stays high (>=1)
CNT_W, 8, width of debounce and pulse counters; must hold max(DB_CYCLES, PULSE_LEN)

Ports:
clk  input  1  single clock; all state updates on posedge clk
rst_n  input  1  synchronous, active-low reset, sampled on posedge clk
set_raw  input  1  raw asynchronous set button
reset_raw  input  1  raw asynchronous reset button
s_out  output  1  registered set pulse to the latch s input
r_out  output  1  registered reset pulse to the latch r input
busy  output  1  high while FSM not in IDLE
dropped  output  1  one-cycle strobe: a set event was discarded by reset priority

Behaviour:
- Reset: on a clk edge with rst_n=0, all state clears. Synchroniser flops=0, debounced levels=0, counters=0, pending flags=0, FSM=IDLE, all outputs=0. Reset asserted mid-pulse drops s_out/r_out to 0 after that edge, and no pending event survives.
- Synchroniser: 2 flops per channel; the output of the second flop is sync_x.
- Debounce, per channel, holding a level db_x and counter cnt_x:
  - sync_x == db_x: cnt_x <= 0.
  - sync_x != db_x and cnt_x == DB_CYCLES-1: db_x <= sync_x, cnt_x <= 0.
  - otherwise: cnt_x <= cnt_x+1.
  - A glitch shorter than DB_CYCLES cycles never changes db_x.
- Edge detect: evt_x = db_x & ~db_x_d, where db_x_d is db_x delayed one cycle. Falling edges are ignored.
- Pending: pend_x is set on evt_x when the FSM cannot consume it that cycle, and cleared when serviced. At most one pending event per channel; further events on that channel while pending are merged.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP. The request req_x is evt_x | pend_x.
  - IDLE:
    - req_r -> PULSE_R. Reset has priority; if req_s is also present, it is discarded, pend_s is cleared and dropped=1 for one cycle.
    - else req_s -> PULSE_S.
    - else stay in IDLE.
  - PULSE_S / PULSE_R:
    - Output high for exactly PULSE_LEN cycles; the pulse counter is loaded on entry.
    - Then -> GAP.
  - GAP:
    - One cycle with both outputs 0.
    - Then -> IDLE. A pending request is serviced from IDLE on the following edge, giving at least 2 low cycles between pulses.
- s_out = (state==PULSE_S), r_out = (state==PULSE_R), both registered state decodes. busy = (state != IDLE).
- Latency, counting edge 1 as the first edge that samples raw=1 on a stable input with the FSM idle:
  - db_x goes high at edge DB_CYCLES+2.
  - The output goes high after edge DB_CYCLES+3 and stays high for PULSE_LEN cycles.
  - With defaults: high after edge 7, low after edge 9.
- Simultaneous events: if both channels accept on the same edge, only r_out pulses and dropped strobes.
- If a reset event arrives during PULSE_S, it is held in pend_r and serviced after GAP. The reverse case (set arriving during PULSE_R) is handled symmetrically.
- Invariant: s_out & r_out == 0 in every cycle, including across reset.

Test Plan:
1. Reset/idle: hold rst_n=0 for 3 cycles with raw inputs toggling -> s_out=r_out=busy=dropped=0 throughout. After release with inputs at 0 -> outputs stay 0.
2. Clean set, defaults: set_raw 0->1 held -> s_out high after edge 7 for exactly 2 cycles, busy high 3 cycles (2 pulse + 1 gap), r_out=0 throughout.
3. Bounce rejection: set_raw toggled with high periods of 1, 2 and 3 cycles separated by 1-cycle lows, then held high -> no pulse during the bounce. Exactly one s_out pulse, DB_CYCLES+3 edges after the final rising edge.
4. Simultaneous press: set_raw and reset_raw rise on the same cycle -> one r_out pulse after edge 7, dropped=1 for one cycle at the FSM's IDLE->PULSE_R edge, no s_out pulse.
5. Back-to-back: reset event accepted during PULSE_S -> s_out 2 cycles, then 2 low cycles, then r_out 2 cycles. The bench checks s_out&r_out==0 every cycle.
6. Reset mid-pulse: assert rst_n=0 during PULSE_R with pend_s set -> r_out=0 after that edge. After release, no s_out pulse appears until set_raw produces a new rising edge.
